// File: rtl/mux_barrido.sv
// rtl/mux_barrido.sv - registered channel mux with fixed (FIJO) and dwell-timed scan (BARRIDO) modes
// Q lags canal by one cycle; cambio is a one-cycle flag registered alongside each scan advance.
module mux_barrido #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int SW    = 2,
  parameter int DWELL = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*W-1:0]  datos,
  input  logic [SW-1:0]   sel,
  input  logic            modo,
  input  logic            en,
  output logic [W-1:0]    Q,
  output logic [SW-1:0]   canal,
  output logic            cambio
);

  localparam int             CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL - 1);
  localparam logic [SW-1:0]  CH_LAST  = SW'(N - 1);

  typedef enum logic {
    FIJO    = 1'b0,
    BARRIDO = 1'b1
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cnt_start;
  logic [SW-1:0]  canal_q, canal_d;
  logic [SW-1:0]  base;
  logic [W-1:0]   q_q, q_d;
  logic           cambio_q, cambio_d;
  logic           canal_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= FIJO;
      cnt_q    <= '0;
      canal_q  <= '0;
      q_q      <= '0;
      cambio_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      canal_q  <= canal_d;
      q_q      <= q_d;
      cambio_q <= cambio_d;
    end
  end

  always_comb begin
    estado_d    = modo ? BARRIDO : FIJO;
    cnt_d       = '0;
    canal_d     = sel;
    cambio_d    = 1'b0;
    q_d         = '0;
    canal_valid = 1'b0;
    base        = '0;
    cnt_start   = '0;

    // Out-of-range indices select nothing, so Q loads zero and a scan restarts at channel 0.
    for (int k = 0; k < N; k++) begin
      if (canal_q == SW'(k)) begin
        q_d         = datos[k*W +: W];
        canal_valid = 1'b1;
      end
    end

    if (modo) begin
      base      = canal_valid ? canal_q : '0;
      cnt_start = (estado_q == BARRIDO) ? cnt_q : '0;
      cnt_d     = cnt_start;
      canal_d   = base;
      if (en) begin
        if (cnt_start == CNT_LAST) begin
          cnt_d    = '0;
          canal_d  = (base == CH_LAST) ? '0 : base + SW'(1);
          cambio_d = 1'b1;
        end else begin
          cnt_d = cnt_start + CW'(1);
        end
      end
    end
  end

  assign Q      = q_q;
  assign canal  = canal_q;
  assign cambio = cambio_q;

endmodule
